keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV_BITS, default 16, width of the free-running divider; one scan tick every 2^SCAN_DIV_BITS clk cycles.
REQ-002 Parameter DEBOUNCE_TICKS, default 4, consecutive stable scan ticks required to accept a press or a release (legal range 1..15).
REQ-003 Parameter REPEAT_TICKS, default 64, scan ticks between auto-repeat events (used only when KEYPAD_REPEAT_EN is defined).
REQ-004 clk  input  1  system clock, single clock domain.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 row_n  input  4  keypad row lines, active-low, externally pulled up, asynchronous to clk.
REQ-007 col_en  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-008 key_valid  output  1  one-clk pulse announcing a new (or repeated) key event.
REQ-009 key_code  output  4  hex code of the last accepted key, {row_idx[1:0], col_idx[1:0]}, stable until the next event.
REQ-010 key_down  output  1  level, high while an accepted key is held.

Function
REQ-011 row_n SHALL pass through a two-flop synchronizer; all decisions use the synchronized value (2 clk latency).
REQ-012 Divider SHALL increment every clk and emit scan_tick as a one-clk pulse when all bits are ones; no derived clocks.
REQ-013 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE; all transitions occur only on scan_tick.
REQ-014 SCAN: if any synced row low, latch col_idx and lowest-numbered low row as row_idx, clear stable counter, go DEBOUNCE; else advance col_idx 0->1->2->3->0 (wrap) and drive col_en = ~(1<<col_idx).
REQ-015 Multiple rows low simultaneously SHALL resolve to the lowest-numbered row.
REQ-016 DEBOUNCE: column held; if latched row still low, increment counter; on reaching DEBOUNCE_TICKS go HELD, pulse key_valid, update key_code, set key_down in the same clk; if latched row high, return SCAN and advance column, no event.
REQ-017 HELD: if latched row high, clear counter, go RELEASE; otherwise stay.
REQ-018 RELEASE: if row stays high for DEBOUNCE_TICKS consecutive ticks, clear key_down, go SCAN advancing column; if row returns low, go HELD with no new key_valid.
REQ-019 key_valid SHALL never be high on two consecutive clks.

Reset
REQ-020 While reset is high: state SCAN, col_idx 0, col_en 4'b1110, key_valid 0, key_code 4'h0, key_down 0, divider 0, counters 0, synchronizer flops 4'hF.
REQ-021 Reset asserted mid-press SHALL drop key_down immediately with no key_valid; after release of reset a still-held key is re-debounced and reported once.

Configuration
REQ-022 Macro KEYPAD_REPEAT_EN: when defined, in HELD a repeat counter counts scan ticks and pulses key_valid (same key_code) every REPEAT_TICKS ticks while held, cleared on entry to HELD; when undefined, exactly one key_valid per press and no repeat counter is synthesized.

Structure
REQ-023 Shared package keypad_pkg SHALL hold the FSM state typedef, the key_code width constant, and column/row count constants (4).
REQ-024 The two-flop synchronizer SHALL be a separate sub-module sync_2ff (parameterized width), reusable by other board-input blocks.

Verification (SCAN_DIV_BITS=2, DEBOUNCE_TICKS=3, REPEAT_TICKS=5)
REQ-025 Reset with row_n=4'hF -> col_en cycles 1110,1101,1011,0111,1110 every 4 clks; key_valid never high.
REQ-026 Hold row 2 low whenever col_en=4'b1101 -> single key_valid pulse, key_code 4'h9, key_down 1 until release debounced.
REQ-027 Row 1 low for only 2 ticks then high -> no key_valid, scanning resumes at next column.
REQ-028 Rows 0 and 3 low together on column 3 -> key_code 4'h3.
REQ-029 Press debounced, then 1-tick release glitch -> key_down stays 1, no second key_valid.
REQ-030 KEYPAD_REPEAT_EN defined, key held 17 ticks after acceptance -> 1 initial plus 3 repeat key_valid pulses, same key_code; reset mid-hold -> key_down 0 same clk.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned NumCols  = 4;
    localparam int unsigned NumRows  = 4;
    localparam int unsigned KeyCodeW = 4;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld,
        StRelease
    } kp_state_e;

    // Index of the lowest-numbered active-low row (0 if none are low).
    function automatic logic [1:0] lowest_low_row(input logic [NumRows-1:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NumRows - 1; i >= 0; i--) begin
            if (!rows_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs, parameterized width and reset value.
module sync_2ff #(
    parameter int unsigned       Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce; define KEYPAD_REPEAT_EN to add auto-repeat
// of key_valid while a key stays held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV_BITS  = 16,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned REPEAT_TICKS   = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NumRows-1:0]  row_n,
    output logic [NumCols-1:0]  col_en,
    output logic                key_valid,
    output logic [KeyCodeW-1:0] key_code,
    output logic                key_down
);

    if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("keypad_scanner: DEBOUNCE_TICKS must be 1..15 and REPEAT_TICKS >= 1");
    end

    localparam logic [3:0] DbLast = 4'(DEBOUNCE_TICKS);

    logic [NumRows-1:0]       row_sync;
    logic [SCAN_DIV_BITS-1:0] div_q;
    logic                     scan_tick;

    kp_state_e             state_q, state_d;
    logic [1:0]            col_q, col_d;
    logic [1:0]            row_q, row_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            cnt_inc;
    logic [KeyCodeW-1:0]   code_q, code_d;
    logic                  down_q, down_d;
    logic                  valid_q, valid_d;
    logic                  row_low;
    logic                  any_low;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned   RepW    = $clog2(REPEAT_TICKS + 1);
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_TICKS);
    logic [RepW-1:0] rep_q, rep_d, rep_inc;
    assign rep_inc = rep_q + RepW'(1);
`endif

    sync_2ff #(
        .Width    (NumRows),
        .ResetVal ({NumRows{1'b1}})
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (row_sync)
    );

    assign scan_tick = &div_q;
    assign row_low   = ~row_sync[row_q];
    assign any_low   = ~&row_sync;
    assign cnt_inc   = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        down_d  = down_q;
        valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = rep_q;
`endif
        if (scan_tick) begin
            unique case (state_q)
                StScan: begin
                    if (any_low) begin
                        row_d   = lowest_low_row(row_sync);
                        cnt_d   = '0;
                        state_d = StDebounce;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                StDebounce: begin
                    if (row_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DbLast) begin
                            state_d = StHeld;
                            valid_d = 1'b1;
                            code_d  = {row_q, col_q};
                            down_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end else begin
                        state_d = StScan;
                        col_d   = col_q + 2'd1;
                    end
                end
                StHeld: begin
                    if (!row_low) begin
                        cnt_d   = '0;
                        state_d = StRelease;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_inc == RepLast) begin
                        rep_d   = '0;
                        valid_d = 1'b1;
                    end else begin
                        rep_d = rep_inc;
                    end
`endif
                end
                StRelease: begin
                    // A bounce back to low resumes the hold without a new event.
                    if (row_low) begin
                        state_d = StHeld;
`ifdef KEYPAD_REPEAT_EN
                        rep_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DbLast) begin
                            state_d = StScan;
                            down_d  = 1'b0;
                            col_d   = col_q + 2'd1;
                        end
                    end
                end
                default: state_d = StScan;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            state_q <= StScan;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            down_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            div_q   <= div_q + SCAN_DIV_BITS'(1);
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            down_q  <= down_d;
            valid_q <= valid_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rep_q <= '0;
        else       rep_q <= rep_d;
    end
`endif

    assign col_en    = ~(4'b0001 << col_q);
    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_down  = down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner; a tick-level keypad model predicts events.
module tb_keypad_scanner;

    localparam int unsigned DivBits = 2;
    localparam int unsigned Db      = 3;
    localparam int unsigned Rep     = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_n;
    logic [3:0]  col_en;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    logic [15:0] pressed;   // bit r*4+c: key at row r, column c is pressed

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV_BITS  (DivBits),
        .DEBOUNCE_TICKS (Db),
        .REPEAT_TICKS   (Rep)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .col_en    (col_en),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_down  (key_down)
    );

    // Physical keypad: a pressed key shorts its row to a column being driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_en[c]) row_n[r] = 1'b0;
            end
        end
    end

    typedef struct {
        logic [3:0] code;
        int         tick;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         tick_no  = 0;

    // Reference model state, advanced once per scan tick.
    int         m_col, m_row, m_low, m_high, m_rep;
    bit         m_lock, m_down, m_rel;
    logic [3:0] m_code;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t, tick %0d)", name, act, exp,
                     $time, tick_no);
        end
    endtask

    function automatic void model_reset();
        m_col  = 0;
        m_row  = 0;
        m_low  = 0;
        m_high = 0;
        m_rep  = 0;
        m_lock = 0;
        m_down = 0;
        m_rel  = 0;
        m_code = 4'h0;
    endfunction

    function automatic void emit();
        ev_t e;
        e.code = m_code;
        e.tick = tick_no;
        exp_q.push_back(e);
    endfunction

    function automatic void model_step();
        logic [3:0] low;
        for (int r = 0; r < 4; r++) low[r] = pressed[r*4+m_col];
        if (!m_lock) begin
            if (low != 4'h0) begin
                m_lock = 1;
                m_low  = 0;
                for (int r = 3; r >= 0; r--) if (low[r]) m_row = r;
            end else begin
                m_col = (m_col + 1) % 4;
            end
        end else if (!m_down) begin
            if (low[m_row]) begin
                m_low++;
                if (m_low == Db) begin
                    m_down = 1;
                    m_rel  = 0;
                    m_rep  = 0;
                    m_code = 4'(m_row * 4 + m_col);
                    emit();
                end
            end else begin
                m_lock = 0;
                m_col  = (m_col + 1) % 4;
            end
        end else if (!m_rel) begin
            if (!low[m_row]) begin
                m_rel  = 1;
                m_high = 0;
            end
`ifdef KEYPAD_REPEAT_EN
            else begin
                m_rep++;
                if (m_rep == Rep) begin
                    m_rep = 0;
                    emit();
                end
            end
`endif
        end else begin
            if (low[m_row]) begin
                m_rel = 0;
                m_rep = 0;
            end else begin
                m_high++;
                if (m_high == Db) begin
                    m_down = 0;
                    m_lock = 0;
                    m_rel  = 0;
                    m_col  = (m_col + 1) % 4;
                end
            end
        end
    endfunction

    // Monitor: per-cycle output checks and event scoreboard.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        logic [3:0] exp_col;
        ev_t        e;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            exp_col = 4'b1111 ^ (4'b0001 << m_col);
            check("col_en", col_en, exp_col);
            check("key_down", key_down, m_down);
            check("key_code", key_code, m_code);
            if (exp_q.size() != 0 && exp_q[0].tick < tick_no) begin
                e = exp_q.pop_front();
                check("missed_event_tick", tick_no, e.tick);
            end
            if (key_valid) begin
                check("valid_back_to_back", prev_valid, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_key_valid", key_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_code", key_code, e.code);
                    check("event_tick", tick_no, e.tick);
                end
            end
            prev_valid = key_valid;
        end
    end

    task automatic tick();
        repeat (4) @(posedge clk);
        #1;
        tick_no++;
        model_step();
    endtask

    task automatic hold(input logic [15:0] mask, input int n);
        pressed = mask;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check({tag, "_key_down"}, key_down, 1'b0);
        check({tag, "_key_valid"}, key_valid, 1'b0);
        check({tag, "_col_en"}, col_en, 4'hE);
        check({tag, "_key_code"}, key_code, 4'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] m;
        int          r1, r2, c;
        reset   = 1'b1;
        pressed = '0;
        model_reset();
        pulse_reset("reset");

        // Idle scanning: column walks through all four positions.
        hold(16'h0000, 8);

        // Row 2 / column 1 held well past debounce.
        hold(16'h0001 << 9, 12);
        check("row2_col1_code", key_code, 4'h9);
        check("row2_col1_down", key_down, 1'b1);
        hold(16'h0000, 8);
        check("row2_col1_released", key_down, 1'b0);

        // Short row 1 press: rejected.
        hold(16'h0001 << 5, 2);
        hold(16'h0000, 6);

        // Rows 0 and 3 on column 3 together: lowest row wins.
        hold((16'h0001 << 3) | (16'h0001 << 15), 10);
        check("multi_row_code", key_code, 4'h3);
        hold(16'h0000, 8);

        // One-tick release glitch after acceptance.
        hold(16'h0001 << 6, 10);
        hold(16'h0000, 1);
        hold(16'h0001 << 6, 6);
        check("glitch_down", key_down, 1'b1);
        hold(16'h0000, 8);

        // Long hold (exercises auto-repeat when enabled).
        hold(16'h0001 << 10, 24);
        hold(16'h0000, 8);

        // Reset while a key is held, then the key is re-reported.
        hold(16'h0001 << 5, 12);
        pulse_reset("midhold");
        hold(16'h0001 << 5, 12);
        hold(16'h0000, 8);

        for (int ep = 0; ep < 30; ep++) begin
            m  = '0;
            c  = $urandom_range(0, 3);
            r1 = $urandom_range(0, 3);
            r2 = $urandom_range(0, 3);
            m[r1*4+c] = 1'b1;
            if ($urandom_range(0, 3) == 0) m[r2*4+c] = 1'b1;
            hold(m, $urandom_range(0, 14));
            if ($urandom_range(0, 3) == 0) begin
                hold(16'h0000, 1);
                hold(m, $urandom_range(1, 8));
            end
            hold(16'h0000, $urandom_range(1, 8));
        end

        hold(16'h0000, 10);
        check("events_outstanding", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
